// File: rtl/dsp_mac_pkg.sv
// Shared types and constants for the dsp_mac_pipe pre-add/multiply/post-add slice.
package dsp_mac_pkg;

  typedef enum logic [1:0] {PRE_B, PRE_ADD, PRE_SUB, PRE_RSV} pre_sel_e;
  typedef enum logic [1:0] {POST_M, POST_C, POST_PCIN, POST_ACC} post_sel_e;

  localparam int MODE_PRE_LSB  = 0;
  localparam int MODE_POST_LSB = 2;
  localparam int SAT_FN_W      = 128;

  // Saturation limits returned sign-extended to SAT_FN_W; callers keep the low w bits.
  function automatic logic [SAT_FN_W-1:0] sat_max(input int w);
    logic [SAT_FN_W-1:0] r;
    r = '0;
    for (int i = 0; i < w - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [SAT_FN_W-1:0] sat_min(input int w);
    logic [SAT_FN_W-1:0] r;
    r = '1;
    for (int i = 0; i < w - 1; i++) r[i] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/dsp_postadd_sat.sv
// Combinational post-adder: operand select, P_W+1 bit add, overflow detect and clamp.
module dsp_postadd_sat
  import dsp_mac_pkg::*;
#(
  parameter int P_W    = 48,
  parameter int SAT_EN = 1
) (
  input  post_sel_e      i_sel,
  input  logic [P_W-1:0] i_m,
  input  logic [P_W-1:0] i_c,
  input  logic [P_W-1:0] i_pcin,
  input  logic [P_W-1:0] i_p,
  input  logic           i_ci,
  input  logic           i_acc_first,
  output logic [P_W-1:0] o_p,
  output logic           o_ovf
);

  localparam logic [SAT_FN_W-1:0] L_MAX_F = sat_max(P_W);
  localparam logic [SAT_FN_W-1:0] L_MIN_F = sat_min(P_W);
  localparam logic [P_W-1:0]      L_MAX   = L_MAX_F[P_W-1:0];
  localparam logic [P_W-1:0]      L_MIN   = L_MIN_F[P_W-1:0];

  logic [P_W-1:0] w_x;
  logic           w_ci;
  logic [P_W:0]   w_sum;

  always_comb begin
    w_x  = '0;
    w_ci = 1'b0;
    case (i_sel)
      POST_C:    begin w_x = i_c;    w_ci = i_ci; end
      POST_PCIN: begin w_x = i_pcin; w_ci = i_ci; end
      POST_ACC:  w_x = i_acc_first ? '0 : i_p;
      default:   ;
    endcase
  end

  assign w_sum = {w_x[P_W-1], w_x} + {i_m[P_W-1], i_m} + {{P_W{1'b0}}, w_ci};
  assign o_ovf = w_sum[P_W] ^ w_sum[P_W-1];

  // Top bit of the wide sum is the true sign, which picks the clamp direction.
  always_comb begin
    o_p = w_sum[P_W-1:0];
    if (SAT_EN != 0 && o_ovf) o_p = w_sum[P_W] ? L_MIN : L_MAX;
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Parametrised DSP slice: 3-stage valid-tracked pipeline with global stall,
// block accumulate and saturating post-add.
module dsp_mac_pipe
  import dsp_mac_pkg::*;
#(
  parameter int A_W     = 18,
  parameter int B_W     = 18,
  parameter int P_W     = 48,
  parameter int ACC_LEN = 4,
  parameter int SAT_EN  = 1
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             CE,
  input  logic             in_valid,
  input  logic [A_W-1:0]   A,
  input  logic [B_W-1:0]   B,
  input  logic [B_W-1:0]   D,
  input  logic [P_W-1:0]   C,
  input  logic [P_W-1:0]   PCIN,
  input  logic             CARRYIN,
  input  logic [3:0]       MODE,
  output logic [B_W-1:0]   BCOUT,
  output logic [A_W+B_W-1:0] M,
  output logic [P_W-1:0]   P,
  output logic [P_W-1:0]   PCOUT,
  output logic             out_valid,
  output logic             out_last,
  output logic             OVF
);

  localparam int M_W   = A_W + B_W;
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

  pre_sel_e       w_pre_sel;
  logic [B_W-1:0] w_pre;
  logic [M_W-1:0] w_prod;
  logic [P_W-1:0] w_m_ext;
  logic [P_W-1:0] w_p;
  logic           w_ovf;
  logic           w_cnt_wrap;

  logic [3:1]     r_vld;
  logic [B_W-1:0] r_bc;
  logic [A_W-1:0] r_a1;
  post_sel_e      r_post1, r_post2;
  logic [P_W-1:0] r_c1, r_c2, r_pcin1, r_pcin2;
  logic           r_ci1, r_ci2;
  logic [M_W-1:0] r_m;
  logic [P_W-1:0] r_p;
  logic           r_last;
  logic           r_ovf;
  logic [CNT_W-1:0] r_cnt;

  assign w_pre_sel = pre_sel_e'(MODE[MODE_PRE_LSB +: 2]);

  always_comb begin
    case (w_pre_sel)
      PRE_ADD: w_pre = D + B;
      PRE_SUB: w_pre = D - B;
      default: w_pre = B;
    endcase
  end

  assign w_prod  = $signed({{A_W{r_bc[B_W-1]}}, r_bc}) * $signed({{B_W{r_a1[A_W-1]}}, r_a1});
  assign w_m_ext = {{(P_W-M_W){r_m[M_W-1]}}, r_m};
  assign w_cnt_wrap = (r_cnt == CNT_LAST);

  dsp_postadd_sat #(.P_W(P_W), .SAT_EN(SAT_EN)) u_post (
    .i_sel       (r_post2),
    .i_m         (w_m_ext),
    .i_c         (r_c2),
    .i_pcin      (r_pcin2),
    .i_p         (r_p),
    .i_ci        (r_ci2),
    .i_acc_first (r_cnt == '0),
    .o_p         (w_p),
    .o_ovf       (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (RST) begin
      r_vld   <= '0;
      r_bc    <= '0;
      r_a1    <= '0;
      r_post1 <= POST_M;
      r_post2 <= POST_M;
      r_c1    <= '0;
      r_c2    <= '0;
      r_pcin1 <= '0;
      r_pcin2 <= '0;
      r_ci1   <= 1'b0;
      r_ci2   <= 1'b0;
      r_m     <= '0;
      r_p     <= '0;
      r_last  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (CE) begin
      r_vld <= {r_vld[2:1], in_valid};
      if (in_valid) begin
        r_bc    <= w_pre;
        r_a1    <= A;
        r_post1 <= post_sel_e'(MODE[MODE_POST_LSB +: 2]);
        r_c1    <= C;
        r_pcin1 <= PCIN;
        r_ci1   <= CARRYIN;
      end
      if (r_vld[1]) begin
        r_m     <= w_prod;
        r_post2 <= r_post1;
        r_c2    <= r_c1;
        r_pcin2 <= r_pcin1;
        r_ci2   <= r_ci1;
      end
      r_last <= 1'b0;
      if (r_vld[2]) begin
        r_p   <= w_p;
        r_ovf <= r_ovf | w_ovf;
        if (r_post2 == POST_ACC) begin
          r_cnt  <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
          r_last <= w_cnt_wrap;
        end else begin
          r_cnt  <= '0;
          r_last <= 1'b1;
        end
      end
    end
  end

  assign BCOUT     = r_bc;
  assign M         = r_m;
  assign P         = r_p;
  assign PCOUT     = r_p;
  assign out_valid = r_vld[3];
  assign out_last  = r_last;
  assign OVF       = r_ovf;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: saturating and wrapping instances checked against a queue model.
module tb_dsp_mac_pipe;

  localparam int A_W = 18, B_W = 18, P_W = 48, ACC_LEN = 4;
  localparam longint MAXP = (64'sd1 <<< (P_W - 1)) - 1;
  localparam longint MINP = -(64'sd1 <<< (P_W - 1));

  logic clk = 1'b0;
  logic RST, CE, in_valid, CARRYIN;
  logic [A_W-1:0] A;
  logic [B_W-1:0] B, D;
  logic [P_W-1:0] C, PCIN;
  logic [3:0] MODE;

  logic [B_W-1:0] bc_s, bc_w;
  logic [A_W+B_W-1:0] m_s, m_w;
  logic [P_W-1:0] p_s, p_w, pc_s, pc_w;
  logic vld_s, vld_w, last_s, last_w, ovf_s, ovf_w;

  int checks = 0, errors = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .ACC_LEN(ACC_LEN), .SAT_EN(1)) u_sat (
    .clk(clk), .RST(RST), .CE(CE), .in_valid(in_valid), .A(A), .B(B), .D(D), .C(C),
    .PCIN(PCIN), .CARRYIN(CARRYIN), .MODE(MODE), .BCOUT(bc_s), .M(m_s), .P(p_s),
    .PCOUT(pc_s), .out_valid(vld_s), .out_last(last_s), .OVF(ovf_s));

  dsp_mac_pipe #(.A_W(A_W), .B_W(B_W), .P_W(P_W), .ACC_LEN(ACC_LEN), .SAT_EN(0)) u_wrap (
    .clk(clk), .RST(RST), .CE(CE), .in_valid(in_valid), .A(A), .B(B), .D(D), .C(C),
    .PCIN(PCIN), .CARRYIN(CARRYIN), .MODE(MODE), .BCOUT(bc_w), .M(m_w), .P(p_w),
    .PCOUT(pc_w), .out_valid(vld_w), .out_last(last_w), .OVF(ovf_w));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint wrapw(input longint x, input int w);
    return (x <<< (64 - w)) >>> (64 - w);
  endfunction

  function automatic longint fixp(input longint sum, input bit sat);
    if (sat && sum > MAXP) return MAXP;
    if (sat && sum < MINP) return MINP;
    return wrapw(sum, P_W);
  endfunction

  // Model: each accepted sample's full result is computed in order at acceptance,
  // then surfaces after 1/2/3 enabled edges as BCOUT/M/P.
  typedef struct {longint bc, m, p0, p1; bit last, ov0, ov1; int age;} ent_t;
  ent_t q[$];
  longint e_bc, e_m, e_p0, e_p1, lp0, lp1;
  bit e_vld, e_last, e_ov0, e_ov1;
  int m_cnt;

  always @(posedge clk) begin
    if (RST) begin
      q.delete();
      e_bc = 0; e_m = 0; e_p0 = 0; e_p1 = 0; lp0 = 0; lp1 = 0;
      e_vld = 0; e_last = 0; e_ov0 = 0; e_ov1 = 0; m_cnt = 0;
    end else if (CE) begin
      foreach (q[i]) q[i].age++;
      if (in_valid) begin
        ent_t s;
        longint pre, base0, base1, s0, s1, cin;
        case (MODE[1:0])
          2'b01:   pre = longint'($signed(D)) + longint'($signed(B));
          2'b10:   pre = longint'($signed(D)) - longint'($signed(B));
          default: pre = longint'($signed(B));
        endcase
        s.bc = wrapw(pre, B_W);
        s.m  = s.bc * longint'($signed(A));
        cin  = (MODE[3:2] == 2'b01 || MODE[3:2] == 2'b10) ? longint'(CARRYIN) : 0;
        case (MODE[3:2])
          2'b00: begin base0 = 0; base1 = 0; end
          2'b01: begin base0 = longint'($signed(C)); base1 = base0; end
          2'b10: begin base0 = longint'($signed(PCIN)); base1 = base0; end
          default: begin base0 = (m_cnt == 0) ? 0 : lp0; base1 = (m_cnt == 0) ? 0 : lp1; end
        endcase
        s0 = base0 + s.m + cin;
        s1 = base1 + s.m + cin;
        s.p0 = fixp(s0, 1'b1);
        s.p1 = fixp(s1, 1'b0);
        s.ov0 = (s0 > MAXP) || (s0 < MINP);
        s.ov1 = (s1 > MAXP) || (s1 < MINP);
        lp0 = s.p0; lp1 = s.p1;
        if (MODE[3:2] == 2'b11) begin
          s.last = (m_cnt == ACC_LEN - 1);
          m_cnt = s.last ? 0 : m_cnt + 1;
        end else begin
          s.last = 1'b1;
          m_cnt = 0;
        end
        s.age = 1;
        q.push_back(s);
      end
      e_vld = 0; e_last = 0;
      foreach (q[i]) begin
        if (q[i].age == 1) e_bc = q[i].bc;
        if (q[i].age == 2) e_m = q[i].m;
        if (q[i].age == 3) begin
          e_p0 = q[i].p0; e_p1 = q[i].p1; e_vld = 1; e_last = q[i].last;
          e_ov0 |= q[i].ov0; e_ov1 |= q[i].ov1;
        end
      end
      if (q.size() > 0 && q[0].age >= 3) q.delete(0);
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("sat.valid", longint'(vld_s), longint'(e_vld));
      chk("sat.last", longint'(last_s), longint'(e_last));
      chk("sat.P", longint'($signed(p_s)), e_p0);
      chk("sat.PCOUT", longint'($signed(pc_s)), e_p0);
      chk("sat.OVF", longint'(ovf_s), longint'(e_ov0));
      chk("sat.BCOUT", longint'($signed(bc_s)), e_bc);
      chk("sat.M", longint'($signed(m_s)), e_m);
      chk("wrap.valid", longint'(vld_w), longint'(e_vld));
      chk("wrap.last", longint'(last_w), longint'(e_last));
      chk("wrap.P", longint'($signed(p_w)), e_p1);
      chk("wrap.PCOUT", longint'($signed(pc_w)), e_p1);
      chk("wrap.OVF", longint'(ovf_w), longint'(e_ov1));
      chk("wrap.BCOUT", longint'($signed(bc_w)), e_bc);
      chk("wrap.M", longint'($signed(m_w)), e_m);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic smp(input logic [3:0] md, input longint a, input longint b, input longint d,
                     input longint c, input longint pc, input bit ci);
    MODE = md; A = a[A_W-1:0]; B = b[B_W-1:0]; D = d[B_W-1:0];
    C = c[P_W-1:0]; PCIN = pc[P_W-1:0]; CARRYIN = ci; in_valid = 1'b1;
  endtask

  longint av[5] = '{1, 2, 3, 4, 1};
  longint pl[5] = '{2, 6, 12, 20, 2};
  bit     ll[5] = '{0, 0, 0, 1, 0};

  initial begin
    RST = 1; CE = 1; in_valid = 0; CARRYIN = 0; A = '0; B = '0; D = '0; C = '0; PCIN = '0; MODE = '0;
    tick; chk_on = 1; tick; RST = 0;
    chk("rst.P", longint'($signed(p_s)), 0);
    chk("rst.OVF", longint'(ovf_s), 0);

    smp(4'b0101, 3, 4, 5, 10, 0, 1); tick; in_valid = 0;
    chk("t1.BCOUT", longint'($signed(bc_s)), 9); tick;
    chk("t1.M", longint'($signed(m_s)), 27); tick;
    chk("t1.P", longint'($signed(p_s)), 38);
    chk("t1.PCOUT", longint'($signed(pc_w)), 38);
    chk("t1.valid", longint'(vld_s), 1);
    chk("t1.last", longint'(last_s), 1); tick;
    chk("t1.pulse", longint'(vld_s), 0);

    smp(4'b1010, 4, 5, 2, 0, 100, 0); tick; in_valid = 0;
    chk("t2.BCOUT", longint'($signed(bc_s)), -3); tick;
    chk("t2.M", longint'($signed(m_s)), -12); tick;
    chk("t2.P", longint'($signed(p_s)), 88);

    for (int i = 0; i < 7; i++) begin
      if (i < 5) smp(4'b1100, av[i], 2, 0, 0, 0, 1);
      else in_valid = 0;
      tick;
      if (i >= 2) begin
        chk("t3.P", longint'($signed(p_s)), pl[i-2]);
        chk("t3.last", longint'(last_s), longint'(ll[i-2]));
      end
    end

    smp(4'b0100, 1, 1, 0, MAXP, 0, 0); tick; in_valid = 0; tick; tick;
    chk("t4.Psat", longint'($signed(p_s)), MAXP);
    chk("t4.Pwrap", longint'($signed(p_w)), MINP);
    chk("t4.OVFsat", longint'(ovf_s), 1);
    chk("t4.OVFwrap", longint'(ovf_w), 1);
    smp(4'b0101, 3, 4, 5, 10, 0, 1); tick; in_valid = 0; tick; tick;
    chk("t4.P2", longint'($signed(p_s)), 38);
    chk("t4.sticky", longint'(ovf_s), 1);
    RST = 1; tick; RST = 0;
    chk("t4.OVFclr", longint'(ovf_w), 0);

    smp(4'b0101, 3, 4, 5, 10, 0, 1); tick; in_valid = 0; tick;
    CE = 0; in_valid = 1; A = 18'd7; tick;
    chk("t5.stall1", longint'(vld_s), 0); tick;
    chk("t5.stall2", longint'(vld_s), 0);
    chk("t5.stallP", longint'($signed(p_s)), 0);
    in_valid = 0; CE = 1; tick;
    chk("t5.late.valid", longint'(vld_s), 1);
    chk("t5.late.P", longint'($signed(p_s)), 38); tick;

    smp(4'b1100, 1, 2, 0, 0, 0, 0); tick;
    smp(4'b1100, 2, 2, 0, 0, 0, 0); tick; in_valid = 0; tick; tick;
    chk("t5.acc2", longint'($signed(p_s)), 6);
    RST = 1; tick; RST = 0;
    chk("t5.rst.P", longint'($signed(p_s)), 0);
    chk("t5.rst.M", longint'($signed(m_s)), 0);
    chk("t5.rst.BCOUT", longint'($signed(bc_s)), 0);
    chk("t5.rst.valid", longint'(vld_s), 0);
    smp(4'b1100, 3, 2, 0, 0, 0, 0); tick; in_valid = 0; tick; tick;
    chk("t5.restart.P", longint'($signed(p_s)), 6);
    chk("t5.restart.last", longint'(last_s), 0);
    tick; tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
